// File: rtl/uart_mem_loader.sv
// UART frame loader: receives a framed, checksummed byte stream and issues
// single-cycle 32-bit word writes into CPU memory while holding the CPU in reset.
module uart_mem_loader #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned ADDR_W       = 12,
    parameter int unsigned MAX_WORDS    = 1024
) (
    input  logic              clk,
    input  logic              in_RST,
    input  logic              rx,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              cpu_hold,
    output logic              done,
    output logic              error
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [16:0]   MAX_CNT   = 17'(MAX_WORDS);
    localparam logic [7:0]    SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_WAIT_HI
    } rx_state_t;

    typedef enum logic [2:0] {
        F_IDLE,
        F_CNT_LO,
        F_CNT_HI,
        F_DATA,
        F_CSUM,
        F_DONE,
        F_ERR
    } frame_state_t;

    // ---------------- RX bit engine ----------------
    logic [1:0]    sync_q;
    logic          rx_s;
    logic          rx_prev_q;
    rx_state_t     rx_st_q, rx_st_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          byte_valid_q, byte_valid_d;
    logic          frame_err_q, frame_err_d;

    assign rx_s = sync_q[1];

    always_comb begin
        rx_st_d      = rx_st_q;
        cnt_d        = cnt_q + 1'b1;
        bit_d        = bit_q;
        shift_d      = shift_q;
        byte_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        case (rx_st_q)
            RX_IDLE: begin
                cnt_d = '0;
                if (rx_prev_q && !rx_s) rx_st_d = RX_START;
            end
            RX_START: begin
                // Mid-start-bit check rejects short low glitches silently.
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    rx_st_d = rx_s ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) rx_st_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        byte_valid_d = 1'b1;
                        rx_st_d      = RX_IDLE;
                    end else begin
                        frame_err_d  = 1'b1;
                        rx_st_d      = RX_WAIT_HI;
                    end
                end
            end
            RX_WAIT_HI: begin
                cnt_d = '0;
                if (rx_s) rx_st_d = RX_IDLE;
            end
            default: begin
                cnt_d   = '0;
                rx_st_d = RX_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge in_RST) begin
        if (in_RST) begin
            sync_q       <= '1;
            rx_prev_q    <= 1'b1;
            rx_st_q      <= RX_IDLE;
            cnt_q        <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            sync_q       <= {sync_q[0], rx};
            rx_prev_q    <= rx_s;
            rx_st_q      <= rx_st_d;
            cnt_q        <= cnt_d;
            bit_q        <= bit_d;
            shift_q      <= shift_d;
            byte_valid_q <= byte_valid_d;
            frame_err_q  <= frame_err_d;
        end
    end

    // ---------------- Frame FSM ----------------
    frame_state_t      fst_q;
    logic [15:0]       count_q;
    logic [15:0]       words_q;
    logic [1:0]        bidx_q;
    logic [31:0]       word_q;
    logic [7:0]        csum_q;
    logic              wr_en_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [31:0]       wr_data_q;
    logic              hold_q;
    logic              done_q;
    logic              err_q;

    always_ff @(posedge clk or posedge in_RST) begin
        if (in_RST) begin
            fst_q     <= F_IDLE;
            count_q   <= '0;
            words_q   <= '0;
            bidx_q    <= '0;
            word_q    <= '0;
            csum_q    <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            hold_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            wr_en_q <= 1'b0;
            // Address and word count advance in the cycle after the strobe.
            if (wr_en_q) begin
                wr_addr_q <= wr_addr_q + 1'b1;
                words_q   <= words_q + 16'd1;
            end
            case (fst_q)
                F_IDLE: begin
                    if (byte_valid_q && shift_q == SYNC_BYTE) begin
                        fst_q     <= F_CNT_LO;
                        hold_q    <= 1'b1;
                        done_q    <= 1'b0;
                        err_q     <= 1'b0;
                        csum_q    <= '0;
                        wr_addr_q <= '0;
                        words_q   <= '0;
                    end
                end
                F_CNT_LO: begin
                    if (byte_valid_q) begin
                        count_q[7:0] <= shift_q;
                        csum_q       <= csum_q ^ shift_q;
                        fst_q        <= F_CNT_HI;
                    end
                end
                F_CNT_HI: begin
                    if (byte_valid_q) begin
                        count_q[15:8] <= shift_q;
                        csum_q        <= csum_q ^ shift_q;
                        bidx_q        <= '0;
                        words_q       <= '0;
                        if ({1'b0, shift_q, count_q[7:0]} > MAX_CNT)
                            fst_q <= F_ERR;
                        else if ({shift_q, count_q[7:0]} == 16'd0)
                            fst_q <= F_CSUM;
                        else
                            fst_q <= F_DATA;
                    end
                end
                F_DATA: begin
                    if (wr_en_q) begin
                        if (words_q + 16'd1 == count_q) fst_q <= F_CSUM;
                    end else if (byte_valid_q) begin
                        csum_q <= csum_q ^ shift_q;
                        word_q <= {shift_q, word_q[31:8]};
                        bidx_q <= bidx_q + 2'd1;
                        if (bidx_q == 2'd3) begin
                            wr_en_q   <= 1'b1;
                            wr_data_q <= {shift_q, word_q[31:8]};
                        end
                    end
                end
                F_CSUM: begin
                    if (byte_valid_q) fst_q <= (shift_q == csum_q) ? F_DONE : F_ERR;
                end
                F_DONE: begin
                    done_q <= 1'b1;
                    hold_q <= 1'b0;
                    fst_q  <= F_IDLE;
                end
                F_ERR: begin
                    err_q  <= 1'b1;
                    hold_q <= 1'b0;
                    fst_q  <= F_IDLE;
                end
                default: fst_q <= F_IDLE;
            endcase
            if (frame_err_q && (fst_q == F_CNT_LO || fst_q == F_CNT_HI ||
                                fst_q == F_DATA   || fst_q == F_CSUM))
                fst_q <= F_ERR;
        end
    end

    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign cpu_hold = hold_q;
    assign done     = done_q;
    assign error    = err_q;

endmodule

// File: tb/tb_uart_mem_loader.sv
// Scoreboard bench for uart_mem_loader: stimulus queues expected writes and
// end-of-frame status; a negedge monitor pops and compares as the DUT reports.
module tb_uart_mem_loader;

    localparam int unsigned CPB = 16;
    localparam int unsigned AW  = 12;

    logic          clk = 1'b0;
    logic          in_RST;
    logic          rx;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [31:0]   wr_data;
    logic          cpu_hold;
    logic          done;
    logic          error;

    uart_mem_loader #(
        .CLKS_PER_BIT(CPB),
        .ADDR_W      (AW),
        .MAX_WORDS   (1024)
    ) dut (
        .clk     (clk),
        .in_RST  (in_RST),
        .rx      (rx),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .cpu_hold(cpu_hold),
        .done    (done),
        .error   (error)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    logic [AW+31:0] wq[$];
    logic [1:0]     sq[$];
    logic [7:0]     tx_q[$];
    logic [AW+31:0] we;
    logic [1:0]     se;
    logic           hold_prev = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        wait_cyc(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            wait_cyc(CPB);
        end
        rx = stop;
        wait_cyc(CPB);
        rx = 1'b1;
        wait_cyc(CPB);
    endtask

    task automatic send_all();
        while (tx_q.size() > 0) send_byte(tx_q.pop_front(), 1'b1);
    endtask

    always @(negedge clk) begin
        if (!in_RST) begin
            if (wr_en) begin
                if (wq.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_wr: got addr 0x%0h data 0x%0h expected no write", wr_addr, wr_data);
                end else begin
                    we = wq.pop_front();
                    chk("wr_addr", 64'(wr_addr), 64'(we[AW+31:32]));
                    chk("wr_data", 64'(wr_data), 64'(we[31:0]));
                    chk("hold_at_wr", 64'(cpu_hold), 64'd1);
                end
            end
            if (hold_prev && !cpu_hold) begin
                if (sq.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_end: got done=%0b error=%0b expected no frame end", done, error);
                end else begin
                    se = sq.pop_front();
                    chk("end_done",  64'(done),  64'(se[1]));
                    chk("end_error", 64'(error), 64'(se[0]));
                end
            end
        end
        hold_prev = cpu_hold;
    end

    initial begin
        rx     = 1'b1;
        in_RST = 1'b1;
        wait_cyc(3);
        chk("rst_wr_en", 64'(wr_en), 64'd0);
        chk("rst_addr",  64'(wr_addr), 64'd0);
        chk("rst_data",  64'(wr_data), 64'd0);
        chk("rst_hold",  64'(cpu_hold), 64'd0);
        chk("rst_done",  64'(done), 64'd0);
        chk("rst_error", 64'(error), 64'd0);
        in_RST = 1'b0;
        wait_cyc(20);

        // Good frame; checksum 0x28 = XOR of the ten bytes after sync.
        wq.push_back({12'd0, 32'h12345678});
        wq.push_back({12'd1, 32'hDEADBEEF});
        sq.push_back(2'b10);
        send_byte(8'hA5, 1'b1);
        chk("good_hold_after_sync", 64'(cpu_hold), 64'd1);
        tx_q = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h28};
        send_all();
        wait_cyc(8);
        chk("good_done",  64'(done), 64'd1);
        chk("good_error", 64'(error), 64'd0);
        chk("good_hold",  64'(cpu_hold), 64'd0);

        // Short low glitch on idle line.
        rx = 1'b0;
        wait_cyc(3);
        rx = 1'b1;
        wait_cyc(40);
        chk("glitch_done",  64'(done), 64'd1);
        chk("glitch_error", 64'(error), 64'd0);
        chk("glitch_hold",  64'(cpu_hold), 64'd0);

        // Bad checksum: writes still land.
        wq.push_back({12'd0, 32'h12345678});
        wq.push_back({12'd1, 32'hDEADBEEF});
        sq.push_back(2'b01);
        tx_q = '{8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h03};
        send_all();
        wait_cyc(8);
        chk("badcs_done",  64'(done), 64'd0);
        chk("badcs_error", 64'(error), 64'd1);
        chk("badcs_hold",  64'(cpu_hold), 64'd0);

        // Count 1025 exceeds limit.
        sq.push_back(2'b01);
        tx_q = '{8'hA5, 8'h01, 8'h04};
        send_all();
        chk("ovf_error", 64'(error), 64'd1);
        chk("ovf_hold",  64'(cpu_hold), 64'd0);

        // Framing error on second data byte; trailing bytes must not write.
        sq.push_back(2'b01);
        tx_q = '{8'hA5, 8'h01, 8'h00, 8'h11};
        send_all();
        chk("frm_hold_before", 64'(cpu_hold), 64'd1);
        send_byte(8'h22, 1'b0);
        tx_q = '{8'h33, 8'h44};
        send_all();
        chk("frm_error", 64'(error), 64'd1);
        chk("frm_done",  64'(done), 64'd0);

        // Noise before sync, zero word count.
        sq.push_back(2'b10);
        tx_q = '{8'h00, 8'hFF, 8'hA5, 8'h00, 8'h00, 8'h00};
        send_all();
        wait_cyc(8);
        chk("zero_done",  64'(done), 64'd1);
        chk("zero_error", 64'(error), 64'd0);

        // Reset during the second data byte.
        tx_q = '{8'hA5, 8'h02, 8'h00, 8'h78};
        send_all();
        chk("rstmid_hold_before", 64'(cpu_hold), 64'd1);
        fork
            send_byte(8'h56, 1'b1);
            begin
                wait_cyc(60);
                in_RST = 1'b1;
                #1;
                chk("rstmid_wr_en", 64'(wr_en), 64'd0);
                chk("rstmid_addr",  64'(wr_addr), 64'd0);
                chk("rstmid_data",  64'(wr_data), 64'd0);
                chk("rstmid_hold",  64'(cpu_hold), 64'd0);
                chk("rstmid_done",  64'(done), 64'd0);
                chk("rstmid_error", 64'(error), 64'd0);
            end
        join
        wait_cyc(10);
        in_RST = 1'b0;
        wait_cyc(20);

        wq.push_back({12'd0, 32'h12345678});
        wq.push_back({12'd1, 32'hDEADBEEF});
        sq.push_back(2'b10);
        tx_q = '{8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h28};
        send_all();
        wait_cyc(8);
        chk("after_rst_done", 64'(done), 64'd1);

        chk("pending_writes", 64'(wq.size()), 64'd0);
        chk("pending_status", 64'(sq.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
